hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_sb_entry.sv | 18 +
 rtl/hazard_scoreboard.sv | 91 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared stall-cause encoding, latency width and parameter range checks for the hazard scoreboard.
package hazard_pkg;
  localparam int LAT_W = 3;
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_RAW    = 2'b01,
    CAUSE_STRUCT = 2'b10,
    CAUSE_BRANCH = 2'b11
  } cause_e;
  function automatic bit lat_ok(input int lat);
    return (lat >= 0) && (lat < (1 << LAT_W));
  endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: per-register saturating down-counter that can be raised to a new latency (max-load).
module hazard_sb_entry
  import hazard_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  output logic [LAT_W-1:0] o_cnt
);
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_dec;
  assign w_dec = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= (i_load && (i_lat > w_dec)) ? i_lat : w_dec;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: latency scoreboard producing RAW, structural (multiply) and branch stall/flush controls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ifid_valid_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_use_rs_i,
  input  logic             ifid_use_rt_i,
  input  logic             ifid_mul_i,
  input  logic             idex_valid_i,
  input  logic             idex_regwrite_i,
  input  logic             idex_memread_i,
  input  logic             idex_mul_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic             branch_i,
  output logic             if_flush_o,
  output logic             id_flush_o,
  output logic             ex_flush_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic [1:0]       stall_cause_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int NREG = 1 << REG_W;
  localparam logic [LAT_W-1:0] LD_L = LAT_W'(LOAD_LAT);
  localparam logic [LAT_W-1:0] MU_L = LAT_W'(MUL_LAT);
  localparam bit MUL_EN = (MUL_LAT != 0);

  if (!lat_ok(LOAD_LAT) || !lat_ok(MUL_LAT) || CNT_W < 1 || REG_W < 1) begin : g_bad_param
    $error("hazard_scoreboard: parameter out of range");
  end

  logic [LAT_W-1:0] w_lat_ex;
  logic [LAT_W-1:0] w_cnt [NREG];
  logic [LAT_W-1:0] r_mbusy;
  logic [CNT_W-1:0] r_stall_cnt;
  logic w_ex_live, w_rec, w_haz_rs, w_haz_rt, w_raw, w_struct, w_br, w_stall;
  cause_e w_cause;

  assign w_lat_ex  = idex_memread_i ? LD_L : idex_mul_i ? MU_L : '0;
  assign w_ex_live = idex_valid_i & idex_regwrite_i & (idex_rd_i != '0) & ~branch_i;
  assign w_rec     = w_ex_live & (w_lat_ex != '0);

  assign w_cnt[0] = '0;
  for (genvar r = 1; r < NREG; r++) begin : g_sb
    hazard_sb_entry u_entry (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_load(w_rec && (idex_rd_i == REG_W'(r))),
      .i_lat (w_lat_ex - 1'b1),
      .o_cnt (w_cnt[r])
    );
  end

  // A producer entering EX this cycle is seen before it reaches the scoreboard.
  assign w_haz_rs = ifid_use_rs_i & (ifid_rs_i != '0) &
                    ((w_cnt[ifid_rs_i] != '0) | (w_rec & (idex_rd_i == ifid_rs_i)));
  assign w_haz_rt = ifid_use_rt_i & (ifid_rt_i != '0) &
                    ((w_cnt[ifid_rt_i] != '0) | (w_rec & (idex_rd_i == ifid_rt_i)));
  assign w_raw    = ifid_valid_i & (w_haz_rs | w_haz_rt);
  assign w_struct = ifid_valid_i & ifid_mul_i & MUL_EN & ((r_mbusy != '0) | (idex_valid_i & idex_mul_i));

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_mbusy <= '0;
    else       r_mbusy <= (idex_valid_i & idex_mul_i & ~branch_i & MUL_EN) ? MU_L - 1'b1 :
                          (r_mbusy != '0) ? r_mbusy - 1'b1 : '0;

  assign w_br    = ~rst_i & branch_i;
  assign w_stall = ~rst_i & ~branch_i & (w_raw | w_struct);
  assign w_cause = w_br ? CAUSE_BRANCH : !w_stall ? CAUSE_NONE : w_raw ? CAUSE_RAW : CAUSE_STRUCT;

  assign if_flush_o    = w_br;
  assign ex_flush_o    = w_br;
  assign id_flush_o    = w_br | w_stall;
  assign pc_write_o    = ~w_stall;
  assign ifid_write_o  = ~w_stall;
  assign stall_cause_o = w_cause;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)                             r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt))   r_stall_cnt <= r_stall_cnt + 1'b1;
  assign stall_cnt_o = r_stall_cnt;
endmodule
